mem_preload_ctrl: RTL and testbench

// - SoC-side receiver of the tb2mem_* preload interface when NO_COMM_PROTOCOL is defined.
// - Buffers testbench word writes and issues them to ICCM or DCCM write ports.
// - Holds the core in reset until tb2mem_finish is seen and all writes have drained.
// - Sits in top_core between the top-level preload ports, the CCM macros and the core reset/fetch-enable.

---
 rtl/mem_preload_pkg.sv | 20 ++
 rtl/top_pkg.sv | 10 +
 rtl/prim_fifo_sync.sv | 66 ++++++
 rtl/mem_preload_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_preload_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_preload_pkg.sv
// ------------------------------------------------------------------
// mem_preload_pkg: types shared by the CCM preload controller.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_preload_pkg;
  localparam int unsigned c_addr_w = 11;

  typedef enum logic [1:0] {LOAD, DRAIN, HOLD, RUN} state_e;
  typedef enum logic {TGT_ICCM, TGT_DCCM} tgt_e;

  typedef struct packed {
    tgt_e                       tgt;
    logic [c_addr_w-1:0]        addr;
    logic [top_pkg::TL_DW-1:0]  wdata;
    logic [top_pkg::TL_DW-1:0]  wmask;
  } preload_entry_t;
endpackage

`default_nettype wire

// File: rtl/top_pkg.sv
// ------------------------------------------------------------------
// top_pkg: SoC-wide bus widths.                           Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package top_pkg;
  localparam int unsigned TL_DW = 32;
endpackage

`default_nettype wire

// File: rtl/prim_fifo_sync.sv
// ------------------------------------------------------------------
// prim_fifo_sync: synchronous FIFO, power-of-two depth, optional
// empty-bypass; accepts a push while full if a pop happens.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module prim_fifo_sync #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  parameter bit          Pass  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);
  localparam int unsigned c_ptr_w = $clog2(Depth);
  localparam logic [c_ptr_w:0] c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

  logic [Width-1:0] r_mem [Depth];
  logic [c_ptr_w:0] r_wptr;
  logic [c_ptr_w:0] r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_take;
  logic             w_store;
  logic             w_bypass;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                    (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
  assign w_take   = rready_i && !w_empty;
  assign wready_o = !w_full || w_take;
  assign w_store  = wvalid_i && wready_o && !w_bypass;

  if (Pass) begin : g_pass
    assign w_bypass = w_empty && wvalid_i && rready_i;
    assign rvalid_o = !w_empty || wvalid_i;
    assign rdata_o  = w_empty ? wdata_i : r_mem[r_rptr[c_ptr_w-1:0]];
  end else begin : g_no_pass
    assign w_bypass = 1'b0;
    assign rvalid_o = !w_empty;
    assign rdata_o  = r_mem[r_rptr[c_ptr_w-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + c_ptr_one;
      if (w_take)  r_rptr <= r_rptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) r_mem[r_wptr[c_ptr_w-1:0]] <= wdata_i;
  end
endmodule

`default_nettype wire

// File: rtl/mem_preload_ctrl.sv
// ------------------------------------------------------------------
// mem_preload_ctrl: buffers testbench preload writes into ICCM/DCCM
// and releases the core from reset once the preload drains.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_preload_ctrl
  import mem_preload_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RST_HOLD_CYC = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tb2iccm_we,
  input  logic                      tb2dccm_we,
  input  logic [top_pkg::TL_DW-1:0] tb2mem_wdata,
  input  logic [top_pkg::TL_DW-1:0] tb2mem_wmask,
  input  logic [c_addr_w-1:0]       tb2mem_waddr,
  input  logic                      tb2mem_finish,
  output logic                      iccm_req_o,
  input  logic                      iccm_gnt_i,
  output logic                      dccm_req_o,
  input  logic                      dccm_gnt_i,
  output logic [c_addr_w-1:0]       mem_addr_o,
  output logic [top_pkg::TL_DW-1:0] mem_wdata_o,
  output logic [top_pkg::TL_DW-1:0] mem_wmask_o,
  output logic                      core_rst_no,
  output logic                      fetch_en_o,
  output logic                      preload_done_o,
  output logic                      preload_err_o
);
  localparam logic [7:0] c_hold_last = 8'(RST_HOLD_CYC - 1);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [7:0]     r_hold_cnt;
  logic [7:0]     w_hold_cnt_nxt;
  logic           r_err;
  logic           r_run;
  preload_entry_t w_push_entry;
  preload_entry_t w_head;
  logic           w_strobe;
  logic           w_dual;
  logic           w_push_req;
  logic           w_fifo_wready;
  logic           w_fifo_rvalid;
  logic           w_pop;
  logic           w_err_set;

  assign w_strobe   = tb2iccm_we || tb2dccm_we;
  assign w_dual     = tb2iccm_we && tb2dccm_we;
  assign w_push_req = w_strobe && (r_state == LOAD);

  // A dual strobe is resolved in favour of ICCM.
  assign w_push_entry.tgt   = tb2iccm_we ? TGT_ICCM : TGT_DCCM;
  assign w_push_entry.addr  = tb2mem_waddr;
  assign w_push_entry.wdata = tb2mem_wdata;
  assign w_push_entry.wmask = tb2mem_wmask;

  assign w_err_set = w_dual || (w_strobe && (r_state != LOAD)) ||
                     (w_push_req && !w_fifo_wready);

  prim_fifo_sync #(
    .Depth (FIFO_DEPTH),
    .Width ($bits(preload_entry_t)),
    .Pass  (1'b0)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (w_push_req),
    .wready_o (w_fifo_wready),
    .wdata_i  (w_push_entry),
    .rvalid_o (w_fifo_rvalid),
    .rready_i (w_pop),
    .rdata_o  (w_head)
  );

  assign iccm_req_o  = w_fifo_rvalid && (w_head.tgt == TGT_ICCM);
  assign dccm_req_o  = w_fifo_rvalid && (w_head.tgt == TGT_DCCM);
  assign mem_addr_o  = w_head.addr;
  assign mem_wdata_o = w_head.wdata;
  assign mem_wmask_o = w_head.wmask;
  assign w_pop       = (iccm_req_o && iccm_gnt_i) || (dccm_req_o && dccm_gnt_i);

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      LOAD:  if (tb2mem_finish) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!w_fifo_rvalid) begin
          w_state_nxt    = HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        if (r_hold_cnt == c_hold_last) w_state_nxt = RUN;
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= LOAD;
      r_hold_cnt <= '0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_run      <= (w_state_nxt == RUN);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign core_rst_no    = r_run;
  assign fetch_en_o     = r_run;
  assign preload_done_o = r_run;
  assign preload_err_o  = r_err;
endmodule

`default_nettype wire

// File: tb/tb_mem_preload_ctrl.sv
// ------------------------------------------------------------------
// tb_mem_preload_ctrl: self-checking bench for mem_preload_ctrl.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_preload_ctrl;
  localparam int DW    = top_pkg::TL_DW;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iccm_we = 1'b0, dccm_we = 1'b0, finish = 1'b0;
  logic [DW-1:0] wdata = '0, wmask = '0;
  logic [10:0]   waddr = '0;
  logic          iccm_gnt = 1'b0, dccm_gnt = 1'b0;
  logic          iccm_req, dccm_req, core_rst_n, fetch_en, done, err;
  logic [10:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          iccm;
    logic [10:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  mem_preload_ctrl #(.FIFO_DEPTH(DEPTH), .RST_HOLD_CYC(HOLD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tb2iccm_we(iccm_we), .tb2dccm_we(dccm_we),
    .tb2mem_wdata(wdata), .tb2mem_wmask(wmask), .tb2mem_waddr(waddr),
    .tb2mem_finish(finish),
    .iccm_req_o(iccm_req), .iccm_gnt_i(iccm_gnt),
    .dccm_req_o(dccm_req), .dccm_gnt_i(dccm_gnt),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .core_rst_no(core_rst_n), .fetch_en_o(fetch_en),
    .preload_done_o(done), .preload_err_o(err)
  );

  task automatic idle();
    iccm_we = 1'b0; dccm_we = 1'b0; finish = 1'b0;
  endtask

  task automatic drive_wr(input bit ic, input bit dc, input logic [10:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    iccm_we = ic; dccm_we = dc; waddr = a; wdata = d; wmask = m;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; idle(); iccm_gnt = 1'b0; dccm_gnt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({iccm_req, dccm_req, core_rst_n, fetch_en, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got req_i/req_d/rst_n/fetch/done/err=%b expected 000000",
               {iccm_req, dccm_req, core_rst_n, fetch_en, done, err});
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    iccm_gnt = 1'b1; dccm_gnt = 1'b1;
    @(negedge clk);
    drive_wr(1, 0, 11'h010, 32'hDEADBEEF, '1);
    @(negedge clk);
    idle();
    n_checks++;
    if ({iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask} !==
        {2'b10, 11'h010, 32'hDEADBEEF, 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL single_write: got req=%b%b addr=%h data=%h mask=%h expected 10 010 deadbeef ffffffff",
               iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask);
    end
    @(negedge clk);
    n_checks++;
    if ({iccm_req, dccm_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_write_pop: got req=%b%b expected 00", iccm_req, dccm_req);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d[3];
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d[i] = $urandom;
      drive_wr(0, 1, 11'(i), d[i], '1);
    end
    @(negedge clk);
    idle();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({iccm_req, dccm_req, mem_addr, mem_wdata} !== {2'b01, 11'h000, d[0]}) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got req=%b%b addr=%h data=%h expected 01 000 %h",
                 k, iccm_req, dccm_req, mem_addr, mem_wdata, d[0]);
      end
      @(negedge clk);
    end
    dccm_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({iccm_req, dccm_req, mem_addr, mem_wdata} !== {2'b01, 11'(i), d[i]}) begin
        n_fail++;
        $display("FAIL stall_order: entry %0d got req=%b%b addr=%h data=%h expected 01 %h %h",
                 i, iccm_req, dccm_req, mem_addr, mem_wdata, 11'(i), d[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({iccm_req, dccm_req, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_end: got req=%b%b err=%b expected 00 0", iccm_req, dccm_req, err);
    end
  endtask

  task automatic test_overflow();
    int seen;
    wr_t w, e;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      w.iccm = 1'b1; w.addr = 11'($urandom); w.data = $urandom; w.mask = $urandom;
      drive_wr(1, 0, w.addr, w.data, w.mask);
      if (i < DEPTH) exp_q.push_back(w);
    end
    @(negedge clk);
    idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_err: got err=%b expected 1", err);
    end
    iccm_gnt = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (iccm_req || dccm_req) begin
        seen++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{1'b0, 11'h0, '0, '0};
        n_checks++;
        if ({iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask} !== {2'b10, e.addr, e.data, e.mask}) begin
          n_fail++;
          $display("FAIL overflow_entry: write %0d got req=%b%b addr=%h data=%h mask=%h expected 10 %h %h %h",
                   seen, iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask, e.addr, e.data, e.mask);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (seen != DEPTH) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d writes expected %0d", seen, DEPTH);
    end
  endtask

  // Reference model: an ordered list of accepted writes, bounded at DEPTH,
  // where a write can take the slot freed by a grant in the same cycle.
  task automatic test_random_traffic();
    bit  model_err, pop, accept, strobe;
    int  r;
    wr_t h, w;
    apply_reset();
    exp_q.delete();
    model_err = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        if ({iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask} !==
            {h.iccm, !h.iccm, h.addr, h.data, h.mask}) begin
          n_fail++;
          $display("FAIL random_head: cycle %0d got req=%b%b addr=%h data=%h mask=%h expected %b%b %h %h %h",
                   cyc, iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask,
                   h.iccm, !h.iccm, h.addr, h.data, h.mask);
        end
      end else if ({iccm_req, dccm_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL random_idle: cycle %0d got req=%b%b expected 00", cyc, iccm_req, dccm_req);
      end
      n_checks++;
      if (err !== model_err) begin
        n_fail++;
        $display("FAIL random_err: cycle %0d got err=%b expected %b", cyc, err, model_err);
      end
      r = $urandom_range(0, 99);
      w.addr = 11'($urandom); w.data = $urandom; w.mask = $urandom;
      drive_wr(r < 3, (r < 3) || (r >= 40 && r < 70), w.addr, w.data, w.mask);
      if (r >= 3 && r < 40) iccm_we = 1'b1;
      iccm_gnt = ($urandom_range(0, 3) != 0);
      dccm_gnt = ($urandom_range(0, 3) != 0);
      strobe = iccm_we || dccm_we;
      w.iccm = iccm_we;
      pop    = (exp_q.size() > 0) && (exp_q[0].iccm ? iccm_gnt : dccm_gnt);
      accept = strobe && ((exp_q.size() < DEPTH) || pop);
      if (pop) void'(exp_q.pop_front());
      if (accept) exp_q.push_back(w);
      if ((iccm_we && dccm_we) || (strobe && !accept)) model_err = 1'b1;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_finish();
    int low;
    apply_reset();
    iccm_gnt = 1'b1; dccm_gnt = 1'b1;
    @(negedge clk);
    drive_wr(1, 0, 11'h123, 32'hA5A5_0001, '1);
    finish = 1'b1;
    @(negedge clk);
    idle();
    n_checks++;
    if ({iccm_req, mem_addr, core_rst_n} !== {1'b1, 11'h123, 1'b0}) begin
      n_fail++;
      $display("FAIL finish_write: got req=%b addr=%h rst_n=%b expected 1 123 0", iccm_req, mem_addr, core_rst_n);
    end
    @(negedge clk);
    n_checks++;
    if ({iccm_req, dccm_req, core_rst_n} !== 3'b000) begin
      n_fail++;
      $display("FAIL finish_empty: got req=%b%b rst_n=%b expected 00 0", iccm_req, dccm_req, core_rst_n);
    end
    // Core stays in reset for HOLD further cycles after the empty FIFO is seen.
    low = 0;
    for (int k = 0; k < HOLD + 10; k++) begin
      @(negedge clk);
      if (core_rst_n) break;
      low++;
    end
    n_checks++;
    if (low != HOLD) begin
      n_fail++;
      $display("FAIL finish_hold: got %0d low cycles expected %0d", low, HOLD);
    end
    n_checks++;
    if ({core_rst_n, fetch_en, done, err} !== 4'b1110) begin
      n_fail++;
      $display("FAIL finish_run: got rst_n/fetch/done/err=%b expected 1110", {core_rst_n, fetch_en, done, err});
    end
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL finish_repeat: got done/err=%b expected 10", {done, err});
    end
  endtask

  task automatic test_post_finish();
    @(negedge clk);
    drive_wr(1, 0, 11'h055, 32'h1234_5678, '1);
    @(negedge clk);
    idle();
    n_checks++;
    if ({iccm_req, dccm_req, err, core_rst_n} !== 4'b0011) begin
      n_fail++;
      $display("FAIL post_finish: got req=%b%b err=%b rst_n=%b expected 00 1 1", iccm_req, dccm_req, err, core_rst_n);
    end
  endtask

  task automatic test_dual_strobe();
    apply_reset();
    @(negedge clk);
    drive_wr(1, 1, 11'h2AA, 32'hCAFE_F00D, 32'h0000_FFFF);
    @(negedge clk);
    idle();
    n_checks++;
    if ({iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask, err} !==
        {2'b10, 11'h2AA, 32'hCAFE_F00D, 32'h0000_FFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL dual_strobe: got req=%b%b addr=%h data=%h mask=%h err=%b expected 10 2aa cafef00d 0000ffff 1",
               iccm_req, dccm_req, mem_addr, mem_wdata, mem_wmask, err);
    end
    iccm_gnt = 1'b1; dccm_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({iccm_req, dccm_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL dual_single_entry: got req=%b%b expected 00", iccm_req, dccm_req);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    @(negedge clk);
    drive_wr(0, 1, 11'h001, 32'h1111_1111, '1);
    @(negedge clk);
    drive_wr(1, 0, 11'h002, 32'h2222_2222, '1);
    finish = 1'b1;
    @(negedge clk);
    idle();
    n_checks++;
    if ({iccm_req, dccm_req, mem_addr} !== {2'b01, 11'h001}) begin
      n_fail++;
      $display("FAIL drain_queued: got req=%b%b addr=%h expected 01 001", iccm_req, dccm_req, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({iccm_req, dccm_req, core_rst_n} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b%b rst_n=%b expected 00 0", iccm_req, dccm_req, core_rst_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({iccm_req, dccm_req, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flush: got req=%b%b err=%b expected 00 0", iccm_req, dccm_req, err);
    end
    drive_wr(1, 0, 11'h3FF, 32'h0BAD_CAFE, '1);
    @(negedge clk);
    idle();
    n_checks++;
    if ({iccm_req, mem_addr, err} !== {1'b1, 11'h3FF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_load: got req=%b addr=%h err=%b expected 1 3ff 0", iccm_req, mem_addr, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stall();
    test_overflow();
    test_random_traffic();
    test_finish();
    test_post_finish();
    test_dual_strobe();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule

`default_nettype wire
